// File: rtl/ball_hybrid_sequencer.sv
// Bouncing-ball hybrid plant sequencer: paces explicit-Euler flight steps, applies the
// damping jump at ground contact, counts bounces and monitors 0 <= x <= H.
module ball_hybrid_sequencer #(
    parameter real CLK_FREQ    = 1.0e6,
    parameter int  STEP_DIV    = 4,
    parameter int  MAX_BOUNCES = 16,
    parameter real V_REST      = 1.0e-3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  real        H_in,
    input  real        g_in,
    input  real        c_in,
    output real        x,
    output real        v,
    output logic [1:0] mode,
    output logic       step_en,
    output logic [7:0] bounce_cnt,
    output logic       at_rest,
    output logic       busy,
    output logic       violation
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLIGHT = 2'd1;
    localparam logic [1:0] S_IMPACT = 2'd2;
    localparam logic [1:0] S_REST   = 2'd3;

    localparam real DT = real'(STEP_DIV) / CLK_FREQ;
    localparam int  CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [7:0] BOUNCE_MAX = 8'(MAX_BOUNCES);
    // With one clock per step every flight cycle is a step cycle, including the first.
    localparam logic SINGLE_STEP = (STEP_DIV == 1) ? 1'b1 : 1'b0;

    logic [1:0]       r_state;
    real              r_x;
    real              r_v;
    real              r_h;
    real              r_g;
    real              r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step_en;
    logic [7:0]       r_bounce;
    logic             r_violation;

    real              w_h_s;
    real              w_g_s;
    real              w_c_s;
    real              w_xn;
    real              w_vn;
    real              w_vi;
    real              w_vi_mag;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_step_wrap;
    logic [7:0]       w_bounce_inc;
    logic             w_out_of_range;

    assign w_xn         = r_x + r_v * DT;
    assign w_vn         = r_v - r_g * DT;
    assign w_vi         = -r_c * r_v;
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_step_wrap  = (r_cnt == CNT_LAST);
    assign w_bounce_inc = (r_bounce >= BOUNCE_MAX) ? r_bounce : r_bounce + 8'd1;
    assign w_out_of_range = (r_state != S_IDLE) && ((r_x < 0.0) || (r_x > r_h));

    // Sanitise requested plant constants and form the post-impact speed magnitude.
    always_comb begin
        w_h_s    = 1.0;
        w_g_s    = 1.0;
        w_c_s    = 0.5;
        w_vi_mag = 0.0;
        if (H_in >= 0.1) w_h_s = H_in; else w_h_s = 1.0;
        if ((g_in > 0.0) && (g_in <= 10.0)) w_g_s = g_in; else w_g_s = 1.0;
        if ((c_in >= 0.0) && (c_in <= 1.0)) w_c_s = c_in; else w_c_s = 0.5;
        if (w_vi < 0.0) w_vi_mag = -w_vi; else w_vi_mag = w_vi;
    end

    // Mode sequencing, plant state update and sticky range monitor.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= 0.0;
            r_v         <= 0.0;
            r_h         <= 1.0;
            r_g         <= 1.0;
            r_c         <= 0.5;
            r_cnt       <= '0;
            r_step_en   <= 1'b0;
            r_bounce    <= 8'd0;
            r_violation <= 1'b0;
        end else begin
            r_step_en   <= 1'b0;
            r_violation <= r_violation | w_out_of_range;
            case (r_state)
                S_IDLE, S_REST: begin
                    r_x <= 0.0;
                    r_v <= 0.0;
                    if (start) begin
                        r_h         <= w_h_s;
                        r_g         <= w_g_s;
                        r_c         <= w_c_s;
                        r_x         <= w_h_s;
                        r_bounce    <= 8'd0;
                        r_violation <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_FLIGHT;
                        r_step_en   <= SINGLE_STEP;
                    end
                end
                S_FLIGHT: begin
                    if (w_step_wrap) begin
                        r_cnt <= '0;
                        r_v   <= w_vn;
                        // Ground contact is judged on the candidate height only.
                        if (w_xn > 0.0) begin
                            r_x       <= w_xn;
                            r_step_en <= SINGLE_STEP;
                        end else begin
                            r_x     <= 0.0;
                            r_state <= S_IMPACT;
                        end
                    end else begin
                        r_cnt     <= w_cnt_inc;
                        r_step_en <= (w_cnt_inc == CNT_LAST);
                    end
                end
                S_IMPACT: begin
                    r_bounce <= w_bounce_inc;
                    if ((w_vi_mag < V_REST) || (w_bounce_inc == BOUNCE_MAX)) begin
                        r_v     <= 0.0;
                        r_state <= S_REST;
                    end else begin
                        r_v       <= w_vi;
                        r_cnt     <= '0;
                        r_state   <= S_FLIGHT;
                        r_step_en <= SINGLE_STEP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x          = r_x;
    assign v          = r_v;
    assign mode       = r_state;
    assign step_en    = r_step_en;
    assign bounce_cnt = r_bounce;
    assign violation  = r_violation;
    assign at_rest    = (r_state == S_REST);
    assign busy       = (r_state == S_FLIGHT) || (r_state == S_IMPACT);

endmodule

// File: tb/tb_ball_hybrid_sequencer.sv
// Scoreboard bench for ball_hybrid_sequencer: three parameterisations share the inputs,
// a cycle model pushes expected state per edge and each scenario task compares it.
module tb_ball_hybrid_sequencer;

    typedef struct {
        int  mode;
        real x;
        real v;
        real h;
        real g;
        real c;
        int  cnt;
        int  bcnt;
        bit  sten;
        bit  viol;
    } mst_t;

    localparam real DT_A = 1.0 / 100.0;
    localparam real DT_C = 4.0 / 100.0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    real  H_in = 1.0;
    real  g_in = 1.0;
    real  c_in = 0.5;

    real x_a, v_a, x_b, v_b, x_c, v_c;
    logic [1:0] mode_a, mode_b, mode_c;
    logic [7:0] bc_a, bc_b, bc_c;
    logic step_en_a, step_en_b, step_en_c;
    logic at_rest_a, at_rest_b, at_rest_c;
    logic busy_a, busy_b, busy_c;
    logic viol_a, viol_b, viol_c;

    mst_t m_a, m_b, m_c, e_a, e_b, e_c;
    mst_t q_a[$];
    mst_t q_b[$];
    mst_t q_c[$];
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ball_hybrid_sequencer #(.CLK_FREQ(100.0), .STEP_DIV(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .H_in(H_in), .g_in(g_in), .c_in(c_in),
        .x(x_a), .v(v_a), .mode(mode_a), .step_en(step_en_a), .bounce_cnt(bc_a),
        .at_rest(at_rest_a), .busy(busy_a), .violation(viol_a));

    ball_hybrid_sequencer #(.CLK_FREQ(100.0), .STEP_DIV(1), .MAX_BOUNCES(3)) u_b (
        .clk(clk), .rst(rst), .start(start), .H_in(H_in), .g_in(g_in), .c_in(c_in),
        .x(x_b), .v(v_b), .mode(mode_b), .step_en(step_en_b), .bounce_cnt(bc_b),
        .at_rest(at_rest_b), .busy(busy_b), .violation(viol_b));

    ball_hybrid_sequencer #(.CLK_FREQ(100.0)) u_c (
        .clk(clk), .rst(rst), .start(start), .H_in(H_in), .g_in(g_in), .c_in(c_in),
        .x(x_c), .v(v_c), .mode(mode_c), .step_en(step_en_c), .bounce_cnt(bc_c),
        .at_rest(at_rest_c), .busy(busy_c), .violation(viol_c));

    function automatic mst_t model_next(input mst_t cur, input real dt, input int sdiv, input int maxb);
        mst_t n;
        real xn;
        real vi;
        n = cur;
        if (rst) begin
            n.mode = 0; n.x = 0.0; n.v = 0.0; n.h = 1.0; n.g = 1.0; n.c = 0.5;
            n.cnt = 0; n.bcnt = 0; n.viol = 1'b0;
        end else begin
            n.viol = cur.viol || (cur.mode != 0 && (cur.x < 0.0 || cur.x > cur.h));
            if (cur.mode == 0 || cur.mode == 3) begin
                if (start) begin
                    n.h = (H_in >= 0.1) ? H_in : 1.0;
                    n.g = (g_in > 0.0 && g_in <= 10.0) ? g_in : 1.0;
                    n.c = (c_in >= 0.0 && c_in <= 1.0) ? c_in : 0.5;
                    n.x = n.h; n.v = 0.0; n.bcnt = 0; n.viol = 1'b0; n.cnt = 0; n.mode = 1;
                end
            end else if (cur.mode == 1) begin
                if (cur.cnt == sdiv - 1) begin
                    n.cnt = 0;
                    xn = cur.x + cur.v * dt;
                    n.v = cur.v - cur.g * dt;
                    if (xn > 0.0) n.x = xn;
                    else begin n.x = 0.0; n.mode = 2; end
                end else begin
                    n.cnt = cur.cnt + 1;
                end
            end else begin
                vi = -cur.c * cur.v;
                n.bcnt = (cur.bcnt < maxb) ? cur.bcnt + 1 : cur.bcnt;
                if ((vi < 0.0 ? -vi : vi) < 1.0e-3 || n.bcnt == maxb) begin
                    n.v = 0.0; n.mode = 3;
                end else begin
                    n.v = vi; n.mode = 1; n.cnt = 0;
                end
            end
        end
        n.sten = (n.mode == 1) && (n.cnt == sdiv - 1);
        return n;
    endfunction

    // Push expectations at drive time, pop them once the DUT has produced the edge.
    task automatic tick();
        m_a = model_next(m_a, DT_A, 1, 16); q_a.push_back(m_a);
        m_b = model_next(m_b, DT_A, 1, 3);  q_b.push_back(m_b);
        m_c = model_next(m_c, DT_C, 4, 16); q_c.push_back(m_c);
        @(posedge clk);
        #1;
        e_a = q_a.pop_front();
        e_b = q_b.pop_front();
        e_c = q_c.pop_front();
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        tick();
        tick();
        n_total++;
        if (mode_a !== 2'd0 || x_a != 0.0 || v_a != 0.0 || bc_a !== 8'd0 || step_en_a !== 1'b0 || viol_a !== 1'b0 || at_rest_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL reset_a: got m=%0d x=%g v=%g bc=%0d se=%b vi=%b req m=0 x=0 v=0 bc=0 se=0 vi=0", mode_a, x_a, v_a, bc_a, step_en_a, viol_a);
        else n_pass++;
        n_total++;
        if (mode_b !== 2'd0 || x_b != 0.0 || v_b != 0.0 || bc_b !== 8'd0 || step_en_b !== 1'b0 || viol_b !== 1'b0)
            $display("FAIL reset_b: got m=%0d x=%g v=%g bc=%0d se=%b req zeros", mode_b, x_b, v_b, bc_b, step_en_b);
        else n_pass++;
        n_total++;
        if (mode_c !== 2'd0 || x_c != 0.0 || v_c != 0.0 || bc_c !== 8'd0 || step_en_c !== 1'b0 || busy_c !== 1'b0)
            $display("FAIL reset_c: got m=%0d x=%g v=%g bc=%0d se=%b req zeros", mode_c, x_c, v_c, bc_c, step_en_c);
        else n_pass++;
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_flight_to_rest();
        int pulses;
        bit seen_imp;
        pulses = 0; seen_imp = 1'b0;
        apply_reset();
        H_in = 1.0; g_in = 10.0; c_in = 0.0; start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            start = 1'b0;
            n_total++;
            if (mode_a !== 2'(e_a.mode) || x_a != e_a.x || v_a != e_a.v || bc_a !== 8'(e_a.bcnt) || step_en_a !== e_a.sten || viol_a !== e_a.viol || at_rest_a !== (e_a.mode == 3) || busy_a !== (e_a.mode == 1 || e_a.mode == 2))
                $display("FAIL flight cyc %0d: got m=%0d x=%g v=%g bc=%0d se=%b vi=%b req m=%0d x=%g v=%g bc=%0d se=%b vi=%b", cyc, mode_a, x_a, v_a, bc_a, step_en_a, viol_a, e_a.mode, e_a.x, e_a.v, e_a.bcnt, e_a.sten, e_a.viol);
            else n_pass++;
            if (step_en_a === 1'b1) pulses++;
            if (mode_a === 2'd2) seen_imp = 1'b1;
            if (e_a.mode == 3) break;
        end
        n_total++;
        if (pulses != 46) $display("FAIL step_count: got %0d pulses req 46", pulses); else n_pass++;
        n_total++;
        if (!seen_imp) $display("FAIL impact_seen: got 0 req 1"); else n_pass++;
        n_total++;
        if (mode_a !== 2'd3 || x_a != 0.0 || v_a != 0.0 || bc_a !== 8'd1 || viol_a !== 1'b0 || at_rest_a !== 1'b1)
            $display("FAIL final_rest: got m=%0d x=%g v=%g bc=%0d vi=%b req m=3 x=0 v=0 bc=1 vi=0", mode_a, x_a, v_a, bc_a, viol_a);
        else n_pass++;
    endtask

    task automatic test_sanitise();
        real pre;
        bit got_imp;
        pre = 0.0; got_imp = 1'b0;
        apply_reset();
        H_in = 0.05; g_in = -3.0; c_in = 1.5; start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (mode_a !== 2'd1 || x_a != 1.0 || v_a != 0.0)
            $display("FAIL sanitise_launch: got m=%0d x=%g v=%g req m=1 x=1 v=0", mode_a, x_a, v_a);
        else n_pass++;
        tick();
        n_total++;
        if (x_a != 1.0 || v_a != -0.01)
            $display("FAIL sanitise_g: got x=%g v=%g req x=1 v=-0.01", x_a, v_a);
        else n_pass++;
        for (int k = 0; k < 400; k++) begin
            tick();
            n_total++;
            if (mode_a !== 2'(e_a.mode) || x_a != e_a.x || v_a != e_a.v || bc_a !== 8'(e_a.bcnt) || step_en_a !== e_a.sten || viol_a !== e_a.viol)
                $display("FAIL sanitise_traj cyc %0d: got m=%0d x=%g v=%g bc=%0d se=%b req m=%0d x=%g v=%g bc=%0d se=%b", cyc, mode_a, x_a, v_a, bc_a, step_en_a, e_a.mode, e_a.x, e_a.v, e_a.bcnt, e_a.sten);
            else n_pass++;
            if (e_a.mode == 2) begin pre = e_a.v; got_imp = 1'b1; end
            else if (got_imp) break;
        end
        n_total++;
        if (!got_imp || mode_a !== 2'd1 || bc_a !== 8'd1 || v_a != -0.5 * pre)
            $display("FAIL sanitise_c: got m=%0d bc=%0d v=%g req m=1 bc=1 v=%g", mode_a, bc_a, v_a, -0.5 * pre);
        else n_pass++;
    endtask

    task automatic test_max_bounces();
        int impacts;
        impacts = 0;
        apply_reset();
        H_in = 1.0; g_in = 10.0; c_in = 1.0; start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            start = 1'b0;
            n_total++;
            if (mode_b !== 2'(e_b.mode) || x_b != e_b.x || v_b != e_b.v || bc_b !== 8'(e_b.bcnt) || step_en_b !== e_b.sten || viol_b !== e_b.viol || at_rest_b !== (e_b.mode == 3))
                $display("FAIL bounces cyc %0d: got m=%0d x=%g v=%g bc=%0d se=%b vi=%b req m=%0d x=%g v=%g bc=%0d se=%b vi=%b", cyc, mode_b, x_b, v_b, bc_b, step_en_b, viol_b, e_b.mode, e_b.x, e_b.v, e_b.bcnt, e_b.sten, e_b.viol);
            else n_pass++;
            if (mode_b === 2'd2) impacts++;
            if (e_b.mode == 3) break;
        end
        n_total++;
        if (impacts != 3 || bc_b !== 8'd3 || mode_b !== 2'd3 || v_b != 0.0)
            $display("FAIL max_bounces: got impacts=%0d bc=%0d m=%0d v=%g req 3 3 3 0", impacts, bc_b, mode_b, v_b);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int pulses;
        pulses = 0;
        apply_reset();
        H_in = 1.0; g_in = 10.0; c_in = 0.0; start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            start = (k >= 10 && k < 15) ? 1'b1 : 1'b0;
            if (k == 9) begin H_in = 0.5; g_in = 2.0; c_in = 0.9; end
            n_total++;
            if (mode_a !== 2'(e_a.mode) || x_a != e_a.x || v_a != e_a.v || bc_a !== 8'(e_a.bcnt) || step_en_a !== e_a.sten)
                $display("FAIL start_ignored cyc %0d: got m=%0d x=%g v=%g bc=%0d se=%b req m=%0d x=%g v=%g bc=%0d se=%b", cyc, mode_a, x_a, v_a, bc_a, step_en_a, e_a.mode, e_a.x, e_a.v, e_a.bcnt, e_a.sten);
            else n_pass++;
            if (step_en_a === 1'b1) pulses++;
            if (e_a.mode == 3) break;
        end
        start = 1'b0;
        n_total++;
        if (pulses != 46 || bc_a !== 8'd1 || mode_a !== 2'd3)
            $display("FAIL start_ignored_end: got pulses=%0d bc=%0d m=%0d req 46 1 3", pulses, bc_a, mode_a);
        else n_pass++;
    endtask

    task automatic test_reset_mid_flight();
        int pulses;
        pulses = 0;
        apply_reset();
        H_in = 1.0; g_in = 10.0; c_in = 0.0; start = 1'b1;
        for (int k = 0; k < 100 && pulses < 20; k++) begin
            tick();
            start = 1'b0;
            if (step_en_a === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != 20 || mode_a !== 2'd1) $display("FAIL reach_step20: got pulses=%0d m=%0d req 20 1", pulses, mode_a); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (mode_a !== 2'd0 || x_a != 0.0 || v_a != 0.0 || step_en_a !== 1'b0 || bc_a !== 8'd0)
            $display("FAIL mid_reset: got m=%0d x=%g v=%g se=%b bc=%0d req 0 0 0 0 0", mode_a, x_a, v_a, step_en_a, bc_a);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (mode_a !== 2'd0 || step_en_a !== 1'b0) $display("FAIL idle_hold: got m=%0d se=%b req 0 0", mode_a, step_en_a); else n_pass++;
        end
        pulses = 0;
        start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            start = 1'b0;
            n_total++;
            if (mode_a !== 2'(e_a.mode) || x_a != e_a.x || v_a != e_a.v || bc_a !== 8'(e_a.bcnt) || step_en_a !== e_a.sten)
                $display("FAIL relaunch cyc %0d: got m=%0d x=%g v=%g bc=%0d se=%b req m=%0d x=%g v=%g bc=%0d se=%b", cyc, mode_a, x_a, v_a, bc_a, step_en_a, e_a.mode, e_a.x, e_a.v, e_a.bcnt, e_a.sten);
            else n_pass++;
            if (step_en_a === 1'b1) pulses++;
            if (e_a.mode == 3) break;
        end
        n_total++;
        if (pulses != 46 || mode_a !== 2'd3) $display("FAIL relaunch_end: got pulses=%0d m=%0d req 46 3", pulses, mode_a); else n_pass++;
    endtask

    task automatic test_step_pacing();
        int pulses;
        int last;
        pulses = 0;
        apply_reset();
        H_in = 1.0; g_in = 10.0; c_in = 0.0; start = 1'b1;
        tick();
        start = 1'b0;
        last = cyc - 1;
        for (int k = 0; k < 208; k++) begin
            tick();
            n_total++;
            if (mode_c !== 2'(e_c.mode) || x_c != e_c.x || v_c != e_c.v || bc_c !== 8'(e_c.bcnt) || step_en_c !== e_c.sten)
                $display("FAIL pacing cyc %0d: got m=%0d x=%g v=%g bc=%0d se=%b req m=%0d x=%g v=%g bc=%0d se=%b", cyc, mode_c, x_c, v_c, bc_c, step_en_c, e_c.mode, e_c.x, e_c.v, e_c.bcnt, e_c.sten);
            else n_pass++;
            if (step_en_c === 1'b1) begin
                pulses++;
                n_total++;
                if (cyc - last != 4) $display("FAIL step_gap: got %0d cycles req 4", cyc - last); else n_pass++;
                last = cyc;
            end
            if (e_c.mode == 2 || e_c.mode == 3) begin
                n_total++;
                if (step_en_c !== 1'b0) $display("FAIL no_pulse_impact_rest: got se=%b m=%0d req se=0", step_en_c, mode_c); else n_pass++;
            end
            if (e_c.mode == 3 && k > 60) break;
        end
        n_total++;
        if (pulses != 12 || mode_c !== 2'd3 || bc_c !== 8'd1) $display("FAIL pacing_end: got pulses=%0d m=%0d bc=%0d req 12 3 1", pulses, mode_c, bc_c); else n_pass++;
    endtask

    initial begin
        m_a = model_next(m_a, DT_A, 1, 16);
        m_b = m_a;
        m_c = m_a;
        test_reset();
        test_flight_to_rest();
        test_sanitise();
        test_max_bounces();
        test_start_ignored();
        test_reset_mid_flight();
        test_step_pacing();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ball_hybrid_sequencer.md
Name: ball_hybrid_sequencer

Overview:
- Discrete-time controller that sequences a bouncing-ball hybrid plant (height x, velocity v) through its continuous-flight and discrete-jump modes.
- Latches sanitised plant constants (H, g, c) on start, paces integration steps and applies the damping jump at ground contact.
- Counts bounces and retires the plant to rest.
- Exposes the mode and a sticky safety monitor so formal properties (0 <= x <= H) attach to one place in the formal RNM test suite.

Parameters:
CLK_FREQ, 1e6 (real), clock frequency in Hz
STEP_DIV, 4, clock cycles per integration step (>=1)
MAX_BOUNCES, 16, bounce count that forces REST (>=1)
V_REST, 1e-3 (real), post-impact speed magnitude below which the ball is declared at rest

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  launch request, sampled on clk
H_in  input  real  requested initial height
g_in  input  real  requested gravity
c_in  input  real  requested damping coefficient
x  output  real  current height
v  output  real  current velocity
mode  output  2  0=IDLE, 1=FLIGHT, 2=IMPACT, 3=REST
step_en  output  1  one-cycle pulse on each integration step
bounce_cnt  output  8  impacts since launch, saturating at MAX_BOUNCES
at_rest  output  1  high while mode==REST
busy  output  1  high in FLIGHT or IMPACT
violation  output  1  sticky safety flag

Behaviour:
- Reset: mode=IDLE, x=0.0, v=0.0, H=1.0, g=1.0, c=0.5, bounce_cnt=0, step counter=0, step_en=0, violation=0. rst overrides every other input in the same cycle. Reset mid-FLIGHT aborts with no further steps.
- dt = STEP_DIV/CLK_FREQ, a real constant.
- IDLE or REST with start=1 (next cycle):
  - H = (H_in>=0.1) ? H_in : 1.0
  - g = (g_in>0.0 && g_in<=10.0) ? g_in : 1.0
  - c = (c_in>=0.0 && c_in<=1.0) ? c_in : 0.5
  - x = H (sanitised value), v = 0.0, bounce_cnt = 0, violation = 0, step counter = 0, mode = FLIGHT.
- start is ignored in FLIGHT and IMPACT.
- FLIGHT:
  - Step counter counts 0..STEP_DIV-1 and wraps. When it wraps, step_en=1 for that cycle and the state update commits.
  - Update: xn = x + v*dt using the old v; v <= v - g*dt.
  - If xn > 0.0: x <= xn and mode stays FLIGHT.
  - Else: x <= 0.0 and mode <= IMPACT. Ground hit is evaluated on xn only.
  - H, g and c hold constant through FLIGHT and IMPACT.
- IMPACT (exactly one cycle, step_en=0):
  - vi = -c*v; bounce_cnt increments, saturating.
  - If |vi| < V_REST or the incremented count == MAX_BOUNCES: v <= 0.0, mode <= REST.
  - Else: v <= vi, mode <= FLIGHT, step counter restarts at 0.
- REST: x=0.0 and v=0.0 held, at_rest=1, waits for start.
- violation sets when mode!=IDLE and (x<0.0 or x>H). It stays set until the next launch or reset. The block keeps running after it sets; it is a monitor only.
- Outputs are registered; mode, busy and at_rest are decoded from the state register.

Test Plan:
- Overrides CLK_FREQ=100, STEP_DIV=1; start with H_in=1.0, g_in=10.0, c_in=0.0 -> exactly 46 step_en pulses, then IMPACT, then REST. Final state: x=0.0, v=0.0, bounce_cnt=1, violation=0.
- start with g_in=-3.0, c_in=1.5, H_in=0.05 -> latched g=1.0, c=0.5, H=1.0; first cycle of FLIGHT has x=1.0, v=0.0.
- Same overrides, c_in=1.0, MAX_BOUNCES=3 -> third IMPACT goes to REST with bounce_cnt=3. Assert x<=H at every cycle or flag violation consistently.
- start pulsed during FLIGHT -> no re-latch, x/v trajectory unchanged, bounce_cnt unchanged.
- rst asserted at step 20 of FLIGHT -> next cycle mode=IDLE, x=0.0, v=0.0, step_en=0, bounce_cnt=0. A later start relaunches normally.
- Default parameters, STEP_DIV=4 -> step_en high exactly 1 cycle in 4, with no pulse in IMPACT or REST.
